agp32_mem_arbiter: RTL and testbench

Two-port memory command arbiter between the agp32 processor's memory command port, a secondary DMA/debug requester and the single shared memory controller port. Captures one-cycle command pulses from each requester and holds the requester's `ready` low while its request is pending or in flight. Serialises the requests with round-robin priority onto the memory port, one at a time, and returns read data to the originator. Memory errors are latched and freeze the arbiter until reset.

---
 rtl/agp32_mem_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_agp32_mem_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agp32_mem_arbiter.sv
// agp32_mem_arbiter
// Shares the single memory controller command port between the agp32 CPU
// and a secondary DMA/debug requester. Each requester owns a one-entry
// command slot; pending slots are served one at a time with round-robin
// priority, and read data is routed back to whoever issued the request.
// A nonzero memory error code freezes the arbiter until reset.
module agp32_mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  cpu_command,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    input  logic [3:0]  cpu_data_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_data_rdata,
    output logic [31:0] cpu_inst_rdata,
    output logic [1:0]  cpu_error,
    input  logic [2:0]  dma_command,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_wstrb,
    output logic        dma_ready,
    output logic [31:0] dma_rdata,
    output logic [2:0]  mem_command,
    output logic [31:0] mem_data_addr,
    output logic [31:0] mem_data_wdata,
    output logic [3:0]  mem_data_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_data_rdata,
    input  logic [31:0] mem_inst_rdata,
    input  logic [1:0]  mem_error,
    output logic        grant_dma
);

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd2;
    localparam logic [2:0] CMD_WRITE = 3'd3;
    localparam logic [2:0] CMD_INTR  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_SKIP  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic        cpuPend_q;
    logic [2:0]  cpuCmd_q;
    logic [31:0] cpuAddr_q;
    logic [31:0] cpuWdata_q;
    logic [3:0]  cpuWstrb_q;

    logic        dmaPend_q;
    logic [2:0]  dmaCmd_q;
    logic [31:0] dmaAddr_q;
    logic [31:0] dmaWdata_q;
    logic [3:0]  dmaWstrb_q;

    logic        lastGrantDma_q;
    logic        grantDma_q;
    logic [2:0]  issueCmd_q;
    logic [31:0] memAddr_q;
    logic [31:0] memWdata_q;
    logic [3:0]  memWstrb_q;

    logic [31:0] cpuDataRdata_q;
    logic [31:0] cpuInstRdata_q;
    logic [31:0] dmaRdata_q;
    logic [1:0]  cpuError_q;

    logic        cpuLegal;
    logic        dmaLegal;
    logic        cpuCapture;
    logic        dmaCapture;
    logic        errorSeen;
    logic        grantSelDma;
    logic        grantValid;
    logic        completeValid;

    // Decode incoming commands, the arbitration winner and the completion event
    always_comb begin
        cpuLegal      = (cpu_command != CMD_NONE) && (cpu_command <= CMD_INTR);
        dmaLegal      = (dma_command == CMD_READ) || (dma_command == CMD_WRITE);
        cpuCapture    = cpuLegal && cpu_ready;
        dmaCapture    = dmaLegal && dma_ready;
        errorSeen     = (state_q != ST_ERR) && (mem_error != 2'd0);
        grantSelDma   = dmaPend_q && (!cpuPend_q || !lastGrantDma_q);
        grantValid    = (state_q == ST_IDLE) && !errorSeen && (cpuPend_q || dmaPend_q);
        completeValid = (state_q == ST_WAIT) && !errorSeen && mem_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a memory error overrides every other transition
    always_comb begin
        state_d = state_q;
        if (errorSeen) begin
            state_d = ST_ERR;
        end else begin
            case (state_q)
                ST_IDLE:  if (cpuPend_q || dmaPend_q) state_d = ST_ISSUE;
                ST_ISSUE: state_d = ST_SKIP;
                ST_SKIP:  state_d = ST_WAIT;
                ST_WAIT:  if (mem_ready) state_d = ST_IDLE;
                ST_ERR:   state_d = ST_ERR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state: single-cycle command pulse and slot readiness
    always_comb begin
        mem_command = (state_q == ST_ISSUE) ? issueCmd_q : CMD_NONE;
        cpu_ready   = !cpuPend_q && (state_q != ST_ERR);
        dma_ready   = !dmaPend_q && (state_q != ST_ERR);
    end

    // CPU slot: latch the request on capture, free it when its transaction completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpuPend_q  <= 1'b0;
            cpuCmd_q   <= CMD_NONE;
            cpuAddr_q  <= 32'd0;
            cpuWdata_q <= 32'd0;
            cpuWstrb_q <= 4'd0;
        end else begin
            if (completeValid && !grantDma_q) begin
                cpuPend_q <= 1'b0;
            end else if (cpuCapture) begin
                cpuPend_q <= 1'b1;
            end
            if (cpuCapture) begin
                cpuCmd_q   <= cpu_command;
                cpuAddr_q  <= cpu_data_addr;
                cpuWdata_q <= cpu_data_wdata;
                cpuWstrb_q <= cpu_data_wstrb;
            end
        end
    end

    // DMA slot: latch the request on capture, free it when its transaction completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmaPend_q  <= 1'b0;
            dmaCmd_q   <= CMD_NONE;
            dmaAddr_q  <= 32'd0;
            dmaWdata_q <= 32'd0;
            dmaWstrb_q <= 4'd0;
        end else begin
            if (completeValid && grantDma_q) begin
                dmaPend_q <= 1'b0;
            end else if (dmaCapture) begin
                dmaPend_q <= 1'b1;
            end
            if (dmaCapture) begin
                dmaCmd_q   <= dma_command;
                dmaAddr_q  <= dma_addr;
                dmaWdata_q <= dma_wdata;
                dmaWstrb_q <= dma_wstrb;
            end
        end
    end

    // Grant: move the winning slot onto the memory port and remember the owner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lastGrantDma_q <= 1'b1;
            grantDma_q     <= 1'b0;
            issueCmd_q     <= CMD_NONE;
            memAddr_q      <= 32'd0;
            memWdata_q     <= 32'd0;
            memWstrb_q     <= 4'd0;
        end else if (grantValid) begin
            lastGrantDma_q <= grantSelDma;
            grantDma_q     <= grantSelDma;
            issueCmd_q     <= grantSelDma ? dmaCmd_q   : cpuCmd_q;
            memAddr_q      <= grantSelDma ? dmaAddr_q  : cpuAddr_q;
            memWdata_q     <= grantSelDma ? dmaWdata_q : cpuWdata_q;
            memWstrb_q     <= grantSelDma ? dmaWstrb_q : cpuWstrb_q;
        end else if (completeValid) begin
            grantDma_q <= 1'b0;
        end
    end

    // Completion: route returned data to the owner; latch the first error code
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpuDataRdata_q <= 32'd0;
            cpuInstRdata_q <= 32'd0;
            dmaRdata_q     <= 32'd0;
            cpuError_q     <= 2'd0;
        end else begin
            if (completeValid) begin
                if (!grantDma_q) begin
                    cpuDataRdata_q <= mem_data_rdata;
                    cpuInstRdata_q <= mem_inst_rdata;
                end else if (issueCmd_q == CMD_READ) begin
                    dmaRdata_q <= mem_data_rdata;
                end
            end
            if (errorSeen) begin
                cpuError_q <= mem_error;
            end
        end
    end

    assign cpu_data_rdata = cpuDataRdata_q;
    assign cpu_inst_rdata = cpuInstRdata_q;
    assign dma_rdata      = dmaRdata_q;
    assign cpu_error      = cpuError_q;
    assign mem_data_addr  = memAddr_q;
    assign mem_data_wdata = memWdata_q;
    assign mem_data_wstrb = memWstrb_q;
    assign grant_dma      = grantDma_q;

endmodule

// File: tb/tb_agp32_mem_arbiter.sv
// Testbench for agp32_mem_arbiter: a behavioural memory pops the expected
// transaction from a scoreboard each time a command pulse appears, checks
// the issued payload and owner, answers it, and checks the routed result.
module tb_agp32_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cpu_command;
    logic [31:0] cpu_data_addr;
    logic [31:0] cpu_data_wdata;
    logic [3:0]  cpu_data_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_data_rdata;
    logic [31:0] cpu_inst_rdata;
    logic [1:0]  cpu_error;
    logic [2:0]  dma_command;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_wstrb;
    logic        dma_ready;
    logic [31:0] dma_rdata;
    logic [2:0]  mem_command;
    logic [31:0] mem_data_addr;
    logic [31:0] mem_data_wdata;
    logic [3:0]  mem_data_wstrb;
    logic        mem_ready;
    logic [31:0] mem_data_rdata;
    logic [31:0] mem_inst_rdata;
    logic [1:0]  mem_error;
    logic        grant_dma;

    typedef struct {
        bit          isDma;
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] respData;
        logic [31:0] respInst;
    } issueRec_t;

    typedef struct {
        bit          isDma;
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] respData;
        logic [31:0] respInst;
        bit          expIssue;
    } vector_t;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          pulseCount = 0;
    bit          autoRespond = 1'b1;
    int          respLat = 2;
    issueRec_t   expQ[$];
    logic [31:0] cpuDataModel = 32'd0;
    logic [31:0] cpuInstModel = 32'd0;
    logic [31:0] dmaRdataModel = 32'd0;

    agp32_mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_command    (cpu_command),
        .cpu_data_addr  (cpu_data_addr),
        .cpu_data_wdata (cpu_data_wdata),
        .cpu_data_wstrb (cpu_data_wstrb),
        .cpu_ready      (cpu_ready),
        .cpu_data_rdata (cpu_data_rdata),
        .cpu_inst_rdata (cpu_inst_rdata),
        .cpu_error      (cpu_error),
        .dma_command    (dma_command),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_wstrb      (dma_wstrb),
        .dma_ready      (dma_ready),
        .dma_rdata      (dma_rdata),
        .mem_command    (mem_command),
        .mem_data_addr  (mem_data_addr),
        .mem_data_wdata (mem_data_wdata),
        .mem_data_wstrb (mem_data_wstrb),
        .mem_ready      (mem_ready),
        .mem_data_rdata (mem_data_rdata),
        .mem_inst_rdata (mem_inst_rdata),
        .mem_error      (mem_error),
        .grant_dma      (grant_dma)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " cpu_ready"},      32'(cpu_ready), 32'd1);
        checkOutput({tag, " dma_ready"},      32'(dma_ready), 32'd1);
        checkOutput({tag, " mem_command"},    32'(mem_command), 32'd0);
        checkOutput({tag, " mem_data_addr"},  mem_data_addr, 32'd0);
        checkOutput({tag, " mem_data_wdata"}, mem_data_wdata, 32'd0);
        checkOutput({tag, " mem_data_wstrb"}, 32'(mem_data_wstrb), 32'd0);
        checkOutput({tag, " cpu_data_rdata"}, cpu_data_rdata, 32'd0);
        checkOutput({tag, " cpu_inst_rdata"}, cpu_inst_rdata, 32'd0);
        checkOutput({tag, " dma_rdata"},      dma_rdata, 32'd0);
        checkOutput({tag, " cpu_error"},      32'(cpu_error), 32'd0);
        checkOutput({tag, " grant_dma"},      32'(grant_dma), 32'd0);
    endtask

    task automatic driveCmd(input bit isDma, input logic [2:0] cmd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        if (isDma) begin
            dma_command = cmd;
            dma_addr    = addr;
            dma_wdata   = wdata;
            dma_wstrb   = wstrb;
        end else begin
            cpu_command    = cmd;
            cpu_data_addr  = addr;
            cpu_data_wdata = wdata;
            cpu_data_wstrb = wstrb;
        end
    endtask

    task automatic applyStimulus(input vector_t v);
        issueRec_t r;
        @(negedge clk);
        driveCmd(v.isDma, v.cmd, v.addr, v.wdata, v.wstrb);
        if (v.expIssue) begin
            r = '{v.isDma, v.cmd, v.addr, v.wdata, v.wstrb, v.respData, v.respInst};
            expQ.push_back(r);
        end
    endtask

    task automatic waitIdle(input string name);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (cpu_ready && dma_ready) break;
        end
        checkOutput(name, 32'(cpu_ready && dma_ready), 32'd1);
    endtask

    function automatic issueRec_t makeRec(input bit isDma, input int k);
        issueRec_t r;
        if (isDma) begin
            r = '{1'b1, ((k % 2) == 1) ? 3'd3 : 3'd2, 32'h2000 + 32'(k * 4),
                  32'h5A5A_0000 + 32'(k), 4'hF, 32'hD0A0_0000 + 32'(k), 32'd0};
        end else begin
            r = '{1'b0, 3'd2, 32'h1000 + 32'(k * 4), 32'd0, 4'h0,
                  32'hC0DE_0000 + 32'(k), 32'h1300_0000 + 32'(k)};
        end
        return r;
    endfunction

    task automatic issueWhenReady(input bit isDma, input int k);
        issueRec_t r;
        bit done;
        done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (isDma) dma_command = 3'd0; else cpu_command = 3'd0;
            if (isDma ? dma_ready : cpu_ready) begin
                r = makeRec(isDma, k);
                driveCmd(isDma, r.cmd, r.addr, r.wdata, r.wstrb);
                expQ.push_back(r);
                done = 1'b1;
            end
        end
        checkOutput($sformatf("contention issued dma=%0d k=%0d", isDma, k), 32'(done), 32'd1);
    endtask

    // Behavioural memory: check each command pulse against the scoreboard and answer it
    initial begin : memResponder
        issueRec_t cur;
        forever begin
            @(negedge clk);
            if (mem_command != 3'd0) begin
                pulseCount++;
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedPulse: got mem_command %0d, expected none", mem_command);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("issue cmd",       32'(mem_command), 32'(cur.cmd));
                    checkOutput("issue addr",      mem_data_addr, cur.addr);
                    checkOutput("issue wdata",     mem_data_wdata, cur.wdata);
                    checkOutput("issue wstrb",     32'(mem_data_wstrb), 32'(cur.wstrb));
                    checkOutput("issue grant_dma", 32'(grant_dma), 32'(cur.isDma));
                    if (autoRespond) begin
                        mem_ready = 1'b0;
                        repeat (respLat) @(negedge clk);
                        mem_data_rdata = cur.respData;
                        mem_inst_rdata = cur.respInst;
                        mem_ready      = 1'b1;
                        @(negedge clk);
                        if (cur.isDma) begin
                            if (cur.cmd == 3'd2) dmaRdataModel = cur.respData;
                            checkOutput("done dma_rdata", dma_rdata, dmaRdataModel);
                            checkOutput("done dma_ready", 32'(dma_ready), 32'd1);
                        end else begin
                            cpuDataModel = cur.respData;
                            cpuInstModel = cur.respInst;
                            checkOutput("done cpu_data_rdata", cpu_data_rdata, cpuDataModel);
                            checkOutput("done cpu_inst_rdata", cpu_inst_rdata, cpuInstModel);
                            checkOutput("done cpu_ready", 32'(cpu_ready), 32'd1);
                        end
                        checkOutput("done grant_dma", 32'(grant_dma), 32'd0);
                    end
                end
            end
        end
    end

    // Runaway guard
    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin : mainSeq
        vector_t vecs[10];
        int p0;

        rst_n = 1'b0;
        driveCmd(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        driveCmd(1'b1, 3'd0, 32'd0, 32'd0, 4'd0);
        mem_ready      = 1'b1;
        mem_data_rdata = 32'd0;
        mem_inst_rdata = 32'd0;
        mem_error      = 2'd0;

        vecs[0] = '{1'b0, 3'd1, 32'h0000_0004, 32'd0,        4'h0, 32'h1111_2222, 32'h0050_0093, 1'b1};
        vecs[1] = '{1'b0, 3'd3, 32'h0000_0200, 32'hCAFEF00D, 4'h3, 32'h3333_4444, 32'h0000_0001, 1'b1};
        vecs[2] = '{1'b0, 3'd4, 32'h0000_0000, 32'd0,        4'h0, 32'h5555_6666, 32'h0000_0002, 1'b1};
        vecs[3] = '{1'b0, 3'd5, 32'h0000_0300, 32'd0,        4'h0, 32'd0,         32'd0,         1'b0};
        vecs[4] = '{1'b0, 3'd7, 32'h0000_0304, 32'd0,        4'h0, 32'd0,         32'd0,         1'b0};
        vecs[5] = '{1'b1, 3'd2, 32'h0000_0300, 32'd0,        4'h0, 32'h0BAD_F00D, 32'd0,         1'b1};
        vecs[6] = '{1'b1, 3'd3, 32'h0000_0304, 32'h12345678, 4'hC, 32'h7777_8888, 32'd0,         1'b1};
        vecs[7] = '{1'b1, 3'd1, 32'h0000_0308, 32'd0,        4'h0, 32'd0,         32'd0,         1'b0};
        vecs[8] = '{1'b1, 3'd4, 32'h0000_030C, 32'd0,        4'h0, 32'd0,         32'd0,         1'b0};
        vecs[9] = '{1'b0, 3'd2, 32'h0000_0400, 32'd0,        4'hF, 32'h9999_AAAA, 32'h0000_0003, 1'b1};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkResetState("reset");

        // Single CPU read with cycle-by-cycle timing
        @(negedge clk);
        driveCmd(1'b0, 3'd2, 32'h100, 32'd0, 4'h0);
        expQ.push_back('{1'b0, 3'd2, 32'h100, 32'd0, 4'h0, 32'hDEADBEEF, 32'h0000_0013});
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            cpu_command = 3'd0;
            checkOutput($sformatf("single c%0d mem_command", c), 32'(mem_command), (c == 2) ? 32'd2 : 32'd0);
            if (c == 2) checkOutput("single c2 mem_data_addr", mem_data_addr, 32'h100);
            checkOutput($sformatf("single c%0d cpu_ready", c), 32'(cpu_ready), (c == 5) ? 32'd1 : 32'd0);
        end
        checkOutput("single cpu_data_rdata", cpu_data_rdata, 32'hDEADBEEF);

        // Table of uncontended requests, including illegal codes that must be dropped
        for (int i = 0; i < 10; i++) begin
            p0 = pulseCount;
            applyStimulus(vecs[i]);
            @(negedge clk);
            cpu_command = 3'd0;
            dma_command = 3'd0;
            checkOutput($sformatf("vec%0d ready after capture", i),
                        32'(vecs[i].isDma ? dma_ready : cpu_ready), 32'(!vecs[i].expIssue));
            waitIdle($sformatf("vec%0d idle", i));
            repeat (2) @(negedge clk);
            checkOutput($sformatf("vec%0d pulses", i), 32'(pulseCount - p0), 32'(vecs[i].expIssue));
        end

        // Tie after reset: CPU must win, then DMA
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cpuDataModel  = 32'd0;
        cpuInstModel  = 32'd0;
        dmaRdataModel = 32'd0;
        p0 = pulseCount;
        @(negedge clk);
        driveCmd(1'b0, 3'd1, 32'h0,  32'd0,  4'h0);
        driveCmd(1'b1, 3'd3, 32'h40, 32'h55, 4'hF);
        expQ.push_back('{1'b0, 3'd1, 32'h0,  32'd0,  4'h0, 32'hA0A0_0001, 32'hB0B0_0001});
        expQ.push_back('{1'b1, 3'd3, 32'h40, 32'h55, 4'hF, 32'hA0A0_0002, 32'd0});
        @(negedge clk);
        cpu_command = 3'd0;
        dma_command = 3'd0;
        waitIdle("tie idle");
        repeat (2) @(negedge clk);
        checkOutput("tie pulses", 32'(pulseCount - p0), 32'd2);
        checkOutput("tie dma_rdata unchanged by write", dma_rdata, 32'd0);

        // Sustained contention: four back-to-back requests from each side
        p0 = pulseCount;
        @(negedge clk);
        begin
            issueRec_t r0;
            r0 = makeRec(1'b0, 0);
            driveCmd(1'b0, r0.cmd, r0.addr, r0.wdata, r0.wstrb);
            expQ.push_back(r0);
            r0 = makeRec(1'b1, 0);
            driveCmd(1'b1, r0.cmd, r0.addr, r0.wdata, r0.wstrb);
            expQ.push_back(r0);
        end
        fork
            begin
                for (int k = 1; k < 4; k++) issueWhenReady(1'b0, k);
                @(negedge clk);
                cpu_command = 3'd0;
            end
            begin
                for (int k = 1; k < 4; k++) issueWhenReady(1'b1, k);
                @(negedge clk);
                dma_command = 3'd0;
            end
        join
        waitIdle("contention idle");
        repeat (2) @(negedge clk);
        checkOutput("contention pulses", 32'(pulseCount - p0), 32'd8);
        checkOutput("contention queue empty", 32'(expQ.size()), 32'd0);

        // Drop while busy: a second DMA read during the first is ignored
        p0 = pulseCount;
        @(negedge clk);
        driveCmd(1'b1, 3'd2, 32'h3000, 32'd0, 4'h0);
        expQ.push_back('{1'b1, 3'd2, 32'h3000, 32'd0, 4'h0, 32'h600DCAFE, 32'd0});
        @(negedge clk);
        dma_command = 3'd0;
        checkOutput("drop dma_ready low", 32'(dma_ready), 32'd0);
        @(negedge clk);
        driveCmd(1'b1, 3'd2, 32'h3004, 32'd0, 4'h0);
        @(negedge clk);
        dma_command = 3'd0;
        waitIdle("drop idle");
        repeat (3) @(negedge clk);
        checkOutput("drop pulses", 32'(pulseCount - p0), 32'd1);
        checkOutput("drop dma_rdata", dma_rdata, 32'h600DCAFE);

        // Error during WAIT freezes the arbiter until reset
        autoRespond = 1'b0;
        mem_ready   = 1'b0;
        p0 = pulseCount;
        @(negedge clk);
        driveCmd(1'b0, 3'd2, 32'h4000, 32'd0, 4'h0);
        expQ.push_back('{1'b0, 3'd2, 32'h4000, 32'd0, 4'h0, 32'd0, 32'd0});
        @(negedge clk);
        cpu_command = 3'd0;
        repeat (3) @(negedge clk);
        mem_error = 2'd2;
        @(negedge clk);
        mem_error = 2'd0;
        checkOutput("err cpu_error", 32'(cpu_error), 32'd2);
        checkOutput("err cpu_ready", 32'(cpu_ready), 32'd0);
        checkOutput("err dma_ready", 32'(dma_ready), 32'd0);
        mem_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cpu_command = (c % 2 == 0) ? 3'd2 : 3'd0;
            dma_command = (c % 3 == 0) ? 3'd3 : 3'd0;
            mem_error   = (c == 4) ? 2'd1 : 2'd0;
        end
        @(negedge clk);
        cpu_command = 3'd0;
        dma_command = 3'd0;
        mem_error   = 2'd0;
        repeat (2) @(negedge clk);
        checkOutput("err pulses frozen", 32'(pulseCount - p0), 32'd1);
        checkOutput("err sticky cpu_error", 32'(cpu_error), 32'd2);
        checkOutput("err cpu_ready held", 32'(cpu_ready), 32'd0);
        checkOutput("err dma_ready held", 32'(dma_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkResetState("post-error reset");

        // Normal operation resumes after reset
        cpuDataModel  = 32'd0;
        cpuInstModel  = 32'd0;
        dmaRdataModel = 32'd0;
        autoRespond   = 1'b1;
        expQ.delete();
        p0 = pulseCount;
        @(negedge clk);
        driveCmd(1'b0, 3'd2, 32'h5000, 32'd0, 4'h0);
        expQ.push_back('{1'b0, 3'd2, 32'h5000, 32'd0, 4'h0, 32'h0123_4567, 32'h89AB_CDEF});
        @(negedge clk);
        cpu_command = 3'd0;
        waitIdle("resume idle");
        repeat (2) @(negedge clk);
        checkOutput("resume pulses", 32'(pulseCount - p0), 32'd1);
        checkOutput("resume cpu_data_rdata", cpu_data_rdata, 32'h0123_4567);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
